pipe_stage_buf: RTL and testbench

Parametrised inter-stage pipeline buffer, the next generation of the fixed-field stage buffers (IF/ID … MEM/WB) in the processor pipeline. Carries an opaque payload and a group of write-enable control bits between two stages with a valid/ready handshake, an optional skid slot for a registered `in_ready`, a global stall, and a synchronous flush that squashes every held entry. Control bits leave the buffer gated by valid, so a bubble or squashed entry never writes the register file.

---
 rtl/pipe_stage_buf.sv | 169 ++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: valid/ready handshake, optional skid slot, stall and flush.
// Define STAGE_BUF_PERF_EN to add the stall/flush/bubble performance counters.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 35,
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned SKID   = 1
`ifdef STAGE_BUF_PERF_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef STAGE_BUF_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  localparam bit HasSkid = (SKID != 0);

  // Head entry (drives the outputs) and skid entry.
  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;

  logic in_fire;
  logic out_fire;
  logic space_ok;

  // With a skid slot, in_ready sees only registered state plus stall/flush.
  always_comb begin
    if (HasSkid) begin
      space_ok = ~s_valid_q;
    end else begin
      space_ok = ~m_valid_q | out_ready;
    end
    in_ready = reset & ~flush & ~stall & space_ok;
    in_fire  = in_valid & in_ready;
    out_fire = m_valid_q & out_ready & ~stall;
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
      m_data_d  = '0;
      s_valid_d = 1'b0;
      s_ctrl_d  = '0;
      s_data_d  = '0;
    end else if (!stall) begin
      if (!m_valid_q) begin
        if (in_fire) begin
          m_valid_d = 1'b1;
          m_ctrl_d  = in_ctrl;
          m_data_d  = in_data;
        end
      end else if (out_fire) begin
        if (s_valid_q) begin
          // Skid entry is older than anything upstream, so it moves up first.
          m_valid_d = 1'b1;
          m_ctrl_d  = s_ctrl_q;
          m_data_d  = s_data_q;
          if (in_fire) begin
            s_ctrl_d = in_ctrl;
            s_data_d = in_data;
          end else begin
            s_valid_d = 1'b0;
          end
        end else if (in_fire) begin
          m_ctrl_d = in_ctrl;
          m_data_d = in_data;
        end else begin
          m_valid_d = 1'b0;
        end
      end else if (in_fire && HasSkid) begin
        s_valid_d = 1'b1;
        s_ctrl_d  = in_ctrl;
        s_data_d  = in_data;
      end
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_ctrl_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_ctrl_q  <= s_ctrl_d;
      s_data_q  <= s_data_d;
    end
  end

  always_comb begin
    out_valid = m_valid_q;
    out_ctrl  = m_ctrl_q & {CTRL_W{m_valid_q}};
    out_data  = m_data_q;
    occupancy = 2'(m_valid_q) + 2'(s_valid_q);
  end

`ifdef STAGE_BUF_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; they only clear on reset.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall && (in_valid || m_valid_q) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (m_valid_q || s_valid_q) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    if (!m_valid_q && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: SKID=1 and SKID=0 instances share stimulus, each checked
// against a queue model. Perf counters are checked when STAGE_BUF_PERF_EN is defined.
module tb_pipe_stage_buf;
  localparam int DW = 35;
  localparam int CW = 3;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          stall = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          ir  [2];
  logic          ov  [2];
  logic [CW-1:0] oc  [2];
  logic [DW-1:0] od  [2];
  logic [1:0]    occ [2];
`ifdef STAGE_BUF_PERF_EN
  logic [15:0]   sc [2];
  logic [15:0]   fc [2];
  logic [15:0]   bc [2];
  int            sc_m, fc_m, bc_m;
`endif

  ent_t q [2][$];
  bit   z [2];
  bit   rdy [2];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(ir[1]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(oc[1]), .out_data(od[1]),
    .occupancy(occ[1])
`ifdef STAGE_BUF_PERF_EN
    , .stall_cnt(sc[1]), .flush_cnt(fc[1]), .bubble_cnt(bc[1])
`endif
  );

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(ir[0]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(oc[0]), .out_data(od[0]),
    .occupancy(occ[0])
`ifdef STAGE_BUF_PERF_EN
    , .stall_cnt(sc[0]), .flush_cnt(fc[0]), .bubble_cnt(bc[0])
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Acceptance from the model's point of view: a skid buffer takes up to two
  // entries; a plain register takes one, or a new one while its head leaves.
  function automatic bit exp_ready(int k);
    int sz = q[k].size();
    bit room = (k == 1) ? (sz < 2) : (sz == 0 || out_ready);
    return reset && !flush && !stall && room;
  endfunction

  task automatic chk_dut(int k);
    string nm = (k == 1) ? "skid1" : "skid0";
    bit    has = q[k].size() > 0;
    ent_t  h = has ? q[k][0] : '0;
    chk({nm, ".in_ready"}, 64'(ir[k]), 64'(exp_ready(k)));
    chk({nm, ".out_valid"}, 64'(ov[k]), 64'(has));
    chk({nm, ".out_ctrl"}, 64'(oc[k]), has ? 64'(h.c) : 64'd0);
    if (has) chk({nm, ".out_data"}, 64'(od[k]), 64'(h.d));
    else if (z[k]) chk({nm, ".out_data_zero"}, 64'(od[k]), 64'd0);
    chk({nm, ".occupancy"}, 64'(occ[k]), 64'(q[k].size()));
  endtask

  task automatic chk_perf();
`ifdef STAGE_BUF_PERF_EN
    chk("skid1.stall_cnt", 64'(sc[1]), 64'(sc_m));
    chk("skid1.flush_cnt", 64'(fc[1]), 64'(fc_m));
    chk("skid1.bubble_cnt", 64'(bc[1]), 64'(bc_m));
`endif
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      z[k] = 1'b1;
    end
`ifdef STAGE_BUF_PERF_EN
    sc_m = 0;
    fc_m = 0;
    bc_m = 0;
`endif
  endtask

  // Entered just after a rising edge; applies inputs, checks, and models the falling edge.
  task automatic cycle(input logic v, input logic fl, input logic st, input logic ordy,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
    ent_t e;
    in_valid  = v;
    flush     = fl;
    stall     = st;
    out_ready = ordy;
    in_ctrl   = c;
    in_data   = d;
    #1;
    chk_dut(0);
    chk_dut(1);
    chk_perf();
    for (int k = 0; k < 2; k++) rdy[k] = exp_ready(k);
`ifdef STAGE_BUF_PERF_EN
    if (st && (v || q[1].size() > 0)) sc_m++;
    if (fl && q[1].size() > 0) fc_m++;
    if (q[1].size() == 0) bc_m++;
`endif
    e.c = c;
    e.d = d;
    for (int k = 0; k < 2; k++) begin
      if (fl) begin
        q[k].delete();
        z[k] = 1'b1;
      end else if (!st) begin
        if (q[k].size() > 0 && ordy) void'(q[k].pop_front());
        if (v && rdy[k]) q[k].push_back(e);
      end
      if (q[k].size() > 0) z[k] = 1'b0;
    end
    @(posedge clk);
  endtask

  initial begin
    logic [DW-1:0] rd;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_dut(0);
    chk_dut(1);
    chk_perf();
    @(posedge clk);
    reset = 1'b1;

    // Streaming with out_ready held high.
    cycle(1, 0, 0, 1, 3'b011, 35'h1);
    cycle(1, 0, 0, 1, 3'b011, 35'h2);
    cycle(1, 0, 0, 1, 3'b011, 35'h3);
    cycle(0, 0, 0, 1, 3'b000, 35'h0);
    cycle(0, 0, 0, 1, 3'b000, 35'h0);

    // Backpressure: 0xC must wait upstream until the skid slot drains.
    cycle(1, 0, 0, 0, 3'b101, 35'hA);
    cycle(1, 0, 0, 0, 3'b101, 35'hB);
    cycle(1, 0, 0, 0, 3'b101, 35'hC);
    #1;
    chk("bp.occupancy", 64'(occ[1]), 64'd2);
    chk("bp.in_ready", 64'(ir[1]), 64'd0);
    cycle(1, 0, 0, 1, 3'b101, 35'hC);
    cycle(1, 0, 0, 1, 3'b101, 35'hC);
    cycle(0, 0, 0, 1, 3'b000, 35'h0);
    cycle(0, 0, 0, 1, 3'b000, 35'h0);

    // Flush with a full buffer.
    cycle(1, 0, 0, 0, 3'b111, 35'h11);
    cycle(1, 0, 0, 0, 3'b111, 35'h22);
    cycle(0, 1, 0, 0, 3'b000, 35'h0);
    #1;
    chk("flush.occupancy", 64'(occ[1]), 64'd0);
    chk("flush.out_data", 64'(od[1]), 64'd0);
    cycle(0, 0, 0, 1, 3'b000, 35'h0);

    // Stall freeze: 0x55 stays visible for three stalled cycles.
    cycle(1, 0, 0, 0, 3'b010, 35'h55);
    cycle(1, 0, 1, 1, 3'b010, 35'h66);
    cycle(1, 0, 1, 1, 3'b010, 35'h66);
    cycle(1, 0, 1, 1, 3'b010, 35'h66);
    #1;
    chk("stall.out_data", 64'(od[1]), 64'h55);
    cycle(1, 1, 1, 1, 3'b010, 35'h66);
    cycle(0, 0, 0, 1, 3'b000, 35'h0);

    // Asynchronous reset between edges while full.
    cycle(1, 0, 0, 0, 3'b001, 35'h7);
    cycle(1, 0, 0, 0, 3'b001, 35'h8);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk_dut(0);
    chk_dut(1);
    chk_perf();
    @(posedge clk);
    reset = 1'b1;

    // SKID=0 pass-through: push while the head pops on the same edge.
    cycle(1, 0, 0, 0, 3'b110, 35'h100);
    cycle(1, 0, 0, 1, 3'b110, 35'h200);
    cycle(1, 0, 0, 1, 3'b110, 35'h300);
    cycle(0, 0, 0, 1, 3'b000, 35'h0);

    for (int i = 0; i < 600; i++) begin
      rd = 35'({$urandom(), $urandom()});
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6,
            3'($urandom_range(0, 7)), rd);
    end
    cycle(0, 0, 0, 1, 3'b000, 35'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
